// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write-back, read-port and reservation bus of the register file
interface register_file_if #(
    parameter int dataWidth = 8,
    parameter int addrWidth = 3
);
    logic                 writeEnable;
    logic [addrWidth-1:0] writeAddr;
    logic [dataWidth-1:0] writeData;
    logic [addrWidth-1:0] readAddrA;
    logic [dataWidth-1:0] readDataA;
    logic                 busyA;
    logic [addrWidth-1:0] readAddrB;
    logic [dataWidth-1:0] readDataB;
    logic                 busyB;
    logic                 reserveEnable;
    logic [addrWidth-1:0] reserveAddr;
    logic [addrWidth:0]   pendingCount;

    modport master (
        output writeEnable, writeAddr, writeData, readAddrA, readAddrB,
               reserveEnable, reserveAddr,
        input  readDataA, busyA, readDataB, busyB, pendingCount
    );

    modport slave (
        input  writeEnable, writeAddr, writeData, readAddrA, readAddrB,
               reserveEnable, reserveAddr,
        output readDataA, busyA, readDataB, busyB, pendingCount
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - register file with two bypassed read ports and a pending scoreboard
module register_file #(
    parameter int dataWidth = 8,
    parameter int addrWidth = 3
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);
    localparam int regCount = 2 ** addrWidth;

    logic [dataWidth-1:0] regs [regCount];
    logic [regCount-1:0]  pending;
    logic [regCount-1:0]  pending_next;
    logic [addrWidth:0]   count;
    logic [addrWidth:0]   count_next;
    logic                 write_hit;
    logic                 reserve_hit;
    logic                 count_inc;
    logic                 count_dec;

    assign write_hit   = bus.writeEnable && (bus.writeAddr != '0);
    assign reserve_hit = bus.reserveEnable && (bus.reserveAddr != '0);

    // A same-address write+reserve keeps the bit set, so the retiring write must not decrement.
    always_comb begin
        pending_next = pending;
        if (write_hit)
            pending_next[bus.writeAddr] = 1'b0;
        if (reserve_hit)
            pending_next[bus.reserveAddr] = 1'b1;
        count_inc  = reserve_hit && !pending[bus.reserveAddr];
        count_dec  = write_hit && pending[bus.writeAddr] &&
                     !(reserve_hit && (bus.reserveAddr == bus.writeAddr));
        count_next = count + {{addrWidth{1'b0}}, count_inc} - {{addrWidth{1'b0}}, count_dec};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < regCount; i++)
                regs[i] <= '0;
            pending <= '0;
            count   <= '0;
        end else begin
            if (write_hit)
                regs[bus.writeAddr] <= bus.writeData;
            pending <= pending_next;
            count   <= count_next;
        end
    end

    always_comb begin
        bus.readDataA = regs[bus.readAddrA];
        bus.busyA     = pending[bus.readAddrA];
        if (bus.readAddrA == '0) begin
            bus.readDataA = '0;
            bus.busyA     = 1'b0;
        end else if (write_hit && (bus.writeAddr == bus.readAddrA)) begin
            bus.readDataA = bus.writeData;
            bus.busyA     = 1'b0;
        end
    end

    always_comb begin
        bus.readDataB = regs[bus.readAddrB];
        bus.busyB     = pending[bus.readAddrB];
        if (bus.readAddrB == '0) begin
            bus.readDataB = '0;
            bus.busyB     = 1'b0;
        end else if (write_hit && (bus.writeAddr == bus.readAddrB)) begin
            bus.readDataB = bus.writeData;
            bus.busyB     = 1'b0;
        end
    end

    assign bus.pendingCount = count;
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed and randomized self-checking bench for register_file
module tb_register_file;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_file_if #(.dataWidth(8), .addrWidth(3)) bus ();

    register_file #(.dataWidth(8), .addrWidth(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] mreg  [8];
    bit         mpend [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int popc();
        int n = 0;
        for (int i = 0; i < 8; i++)
            n += int'(mpend[i]);
        return n;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        if (bus.writeEnable && bus.writeAddr == a) return bus.writeData;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [2:0] a);
        if (a == 3'd0) return 1'b0;
        if (bus.writeEnable && bus.writeAddr == a) return 1'b0;
        return mpend[a];
    endfunction

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic re, input logic [2:0] rsa);
        bus.writeEnable   = we;
        bus.writeAddr     = wa;
        bus.writeData     = wd;
        bus.readAddrA     = ra;
        bus.readAddrB     = rb;
        bus.reserveEnable = re;
        bus.reserveAddr   = rsa;
    endtask

    // Compare against the model before the edge, then apply the architectural rules at the edge.
    task automatic step(input bit do_chk);
        @(negedge clk);
        if (do_chk) begin
            chk("readDataA",    32'(bus.readDataA),    32'(exp_rd(bus.readAddrA)));
            chk("busyA",        32'(bus.busyA),        32'(exp_busy(bus.readAddrA)));
            chk("readDataB",    32'(bus.readDataB),    32'(exp_rd(bus.readAddrB)));
            chk("busyB",        32'(bus.busyB),        32'(exp_busy(bus.readAddrB)));
            chk("pendingCount", 32'(bus.pendingCount), 32'(popc()));
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mreg[i]  = 8'h00;
                mpend[i] = 1'b0;
            end
        end else begin
            if (bus.writeEnable && bus.writeAddr != 3'd0) begin
                mreg[bus.writeAddr]  = bus.writeData;
                mpend[bus.writeAddr] = 1'b0;
            end
            if (bus.reserveEnable && bus.reserveAddr != 3'd0)
                mpend[bus.reserveAddr] = 1'b1;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step(0);
        reset = 1'b0;

        // reset state on every address
        for (int a = 0; a < 8; a++) begin
            drive(0, 0, 0, 3'(a), 3'(7 - a), 0, 0);
            #1;
            chk("rst_rdA", 32'(bus.readDataA), 32'h0);
            chk("rst_busyB", 32'(bus.busyB), 32'h0);
            step(1);
        end
        chk("rst_cnt", 32'(bus.pendingCount), 32'h0);

        // bypass then array read
        drive(1, 3, 8'hAA, 3, 0, 0, 0);
        #1 chk("wr3_bypass", 32'(bus.readDataA), 32'hAA);
        step(1);
        drive(0, 0, 0, 3, 0, 0, 0);
        #1 chk("wr3_array", 32'(bus.readDataA), 32'hAA);
        step(1);

        // register 0 ignores writes and reserves
        drive(1, 0, 8'hFF, 0, 0, 0, 0);
        step(1);
        drive(0, 0, 0, 0, 0, 1, 0);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r0_data", 32'(bus.readDataA), 32'h0);
        chk("r0_busy", 32'(bus.busyA), 32'h0);
        chk("r0_cnt", 32'(bus.pendingCount), 32'h0);
        step(1);

        // reserve then retire register 5
        drive(0, 0, 0, 0, 5, 1, 5);
        step(1);
        drive(1, 5, 8'h55, 0, 5, 0, 0);
        #1;
        chk("r5_cnt_one", 32'(bus.pendingCount), 32'h1);
        chk("r5_busy_byp", 32'(bus.busyB), 32'h0);
        chk("r5_data_byp", 32'(bus.readDataB), 32'h55);
        step(1);
        drive(0, 0, 0, 0, 5, 0, 0);
        #1;
        chk("r5_cnt_zero", 32'(bus.pendingCount), 32'h0);
        chk("r5_busy", 32'(bus.busyB), 32'h0);
        chk("r5_data", 32'(bus.readDataB), 32'h55);
        step(1);

        // same-address write+reserve keeps pending
        drive(0, 0, 0, 2, 4, 1, 2);
        step(1);
        drive(0, 0, 0, 2, 4, 1, 4);
        step(1);
        drive(1, 2, 8'h11, 2, 4, 1, 2);
        #1 chk("wr_res_cnt_before", 32'(bus.pendingCount), 32'h2);
        step(1);
        drive(0, 0, 0, 2, 4, 0, 0);
        #1;
        chk("wr_res_data", 32'(bus.readDataA), 32'h11);
        chk("wr_res_busy", 32'(bus.busyA), 32'h1);
        chk("wr_res_cnt", 32'(bus.pendingCount), 32'h2);
        step(1);
        drive(1, 4, 8'h44, 2, 4, 0, 0);
        step(1);
        drive(0, 0, 0, 2, 4, 0, 0);
        #1 chk("wr4_cnt", 32'(bus.pendingCount), 32'h1);
        step(1);

        // fill 1..7, reserve three, then reset alongside a write
        for (int a = 1; a < 8; a++) begin
            drive(1, 3'(a), 8'(a), 3'(a), 0, 0, 0);
            step(1);
        end
        drive(0, 0, 0, 1, 3, 1, 1); step(1);
        drive(0, 0, 0, 1, 3, 1, 3); step(1);
        drive(0, 0, 0, 1, 3, 1, 6); step(1);
        drive(1, 1, 8'hEE, 1, 3, 0, 0);
        #1 chk("pre_rst_cnt", 32'(bus.pendingCount), 32'h3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            drive(0, 0, 0, 3'(a), 3'(7 - a), 0, 0);
            #1;
            chk("post_rst_rdA", 32'(bus.readDataA), 32'h0);
            chk("post_rst_busyA", 32'(bus.busyA), 32'h0);
            chk("post_rst_cnt", 32'(bus.pendingCount), 32'h0);
            step(1);
        end

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            step(1);
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
